partoserial_idle_tx: RTL
========================

// Module: partoserial_idle_tx
// PURPOSE
//  Parallel-to-serial transmitter for the PHY lane, opposite end of the serial-to-parallel IDLE receiver.
//  - Serializes 8-bit words MSB first, one bit per clk_32f.
//  - Sends a comma preamble after reset so the far-end receiver can lock and go active.
//  - Fills every word slot with no valid upstream data with the IDLE comma 0xBC.
// PARAMETERS
//  INIT_IDLES  8      comma words sent after reset before data is accepted (must be >= 5 for receiver lock)
//  COMMA       8'hBC  idle/comma symbol
// PORTS
//  clk_32f    in   1  bit clock; single clock domain
//  reset      in   1  synchronous, active-high reset
//  data_in    in   8  parallel word from upstream, sampled only when ready_out=1
//  valid_in   in   1  data_in holds a word to send
//  ready_out  out  1  word slot open; data_in/valid_in consumed on this cycle's closing edge
//  data_out   out  1  serial line, registered, MSB first
//  active     out  1  preamble done; data words may be sent
//  sending    out  1  the word currently on data_out is data, not filler comma
//  comma_err  out  1  one-cycle pulse: a valid data word equal to COMMA was loaded
// BEHAVIOUR
//  Reset (edge with reset=1):
//  - Outputs: data_out=0, ready_out=0, active=0, sending=0, comma_err=0.
//  - Internal: bit_cnt=7, sr=0, idle_cnt=0. Abandons any partial word immediately.
//  Internal registers: sr[7:0] shift register, bit_cnt[2:0], idle_cnt 0..INIT_IDLES.
//  Each non-reset edge:
//  - If bit_cnt==7, load word W into sr: data_out<=W[7], bit_cnt<=0.
//  - Otherwise, shift: data_out<=sr[6], sr<=sr<<1, bit_cnt<=bit_cnt+1.
//  - Each word occupies exactly 8 cycles.
//  Word select at load:
//  - W=data_in if active && ready_out && valid_in; sending<=1.
//  - Else W=COMMA; sending<=0.
//  States:
//  - INIT: active=0. Every load is COMMA; idle_cnt increments per load.
//  - The load that brings idle_cnt to INIT_IDLES also sets active<=1 (state RUN).
//  - RUN: active stays 1 until reset.
//  Handshake:
//  - ready_out is registered and high for exactly the one cycle in which bit_cnt==7 && active.
//  - Low at all other times.
//  - valid_in while ready_out=0 is ignored, not consumed; upstream must hold data.
//  Latency:
//  - Consumed word's MSB on data_out after the consuming edge; LSB 7 cycles later.
//  Throughput:
//  - Valid on every ready_out gives back-to-back data with no comma gaps.
//  Timing (INIT_IDLES=8, edge 1 = first edge with reset=0):
//  - Comma k loaded at edge 8k-7; active=1 from edge 57.
//  - ready_out high between edges 64 and 65; first data loaded at edge 65.
//  COMMA as data:
//  - Transmitted unchanged with sending=1; comma_err pulses that cycle.
//  - The receiver treats it as idle.
// TESTING
//  1. Reset 2 cycles, valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0; active rises edge 57; ready_out first high after edge 64.
//  2. Offer 0xA5 at first ready -> edges 65..72 give 1,0,1,0,0,1,0,1; sending=1 for those 8 cycles, then comma with sending=0.
//  3. Words 0x01,0xFF,0x3C valid at every ready -> 24 contiguous data bits, no comma between, ready_out pulses every 8 cycles.
//  4. valid_in=1 with 0x55 held only while ready_out=0 -> not consumed, commas continue; same word taken at next ready_out.
//  5. Valid 0xBC -> comma_err single-cycle pulse, sending=1; reset at bit 3 of a data word -> data_out=0, active=0, 8-comma preamble restarts.
//  6. Loopback into serial-to-parallel IDLE receiver (clk_4f = clk_32f/8, word-aligned) -> receiver goes active, valid_out=1, data_out matches the sent sequence.

Source files
------------

// File: rtl/partoserial_idle_tx.sv
`default_nettype none
// ============================================================================
// Module      : partoserial_idle_tx
// Description : Parallel-to-serial lane transmitter. Sends an 8-bit word per
//               8 clk_32f cycles, MSB first. After reset it emits a preamble
//               of COMMA words so the far-end receiver can lock, then sends
//               upstream data when offered and COMMA (idle) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module partoserial_idle_tx #(
  parameter int         INIT_IDLES = 8,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active,
  output logic       sending,
  output logic       comma_err
);

  // Counter wide enough to hold the value INIT_IDLES itself.
  localparam int             C_CW    = $clog2(INIT_IDLES + 1);
  localparam logic [C_CW-1:0] C_IDLES = C_CW'(INIT_IDLES);

  // INIT: preamble in progress; RUN: data words may be sent.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [C_CW-1:0] idle_cnt_q, idle_cnt_d;
  logic            data_out_q, data_out_d;
  logic            ready_out_q, ready_out_d;
  logic            sending_q, sending_d;
  logic            comma_err_q, comma_err_d;

  logic            w_take;
  logic [7:0]      w_word;

  // Next-state: load a new word every 8th cycle, shift otherwise.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    data_out_d  = data_out_q;
    sending_d   = sending_q;
    comma_err_d = 1'b0;
    // A word is only consumed on the slot that was advertised via ready_out.
    w_take      = (state_q == ST_RUN) && ready_out_q && valid_in;
    w_word      = w_take ? data_in : COMMA;

    if (bit_cnt_q == 3'd7) begin
      sr_d        = w_word;
      data_out_d  = w_word[7];
      bit_cnt_d   = 3'd0;
      sending_d   = w_take;
      comma_err_d = w_take && (data_in == COMMA);
      if (state_q == ST_INIT) begin
        idle_cnt_d = idle_cnt_q + 1'b1;
        if (idle_cnt_d == C_IDLES) begin
          state_d = ST_RUN;
        end
      end
    end else begin
      data_out_d = sr_q[6];
      sr_d       = {sr_q[6:0], 1'b0};
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    // Registered so it is high exactly in the cycle preceding a load edge.
    ready_out_d = (state_d == ST_RUN) && (bit_cnt_d == 3'd7);
  end

  // State register with synchronous reset; partial words are dropped.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd7;
      idle_cnt_q  <= '0;
      data_out_q  <= 1'b0;
      ready_out_q <= 1'b0;
      sending_q   <= 1'b0;
      comma_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      data_out_q  <= data_out_d;
      ready_out_q <= ready_out_d;
      sending_q   <= sending_d;
      comma_err_q <= comma_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign ready_out = ready_out_q;
  assign active    = (state_q == ST_RUN);
  assign sending   = sending_q;
  assign comma_err = comma_err_q;

endmodule
`default_nettype wire
